sr_bank_driver: RTL and testbench

- Sequencer that accepts "write this value" requests over a valid/ready handshake.
- Turns each request into legal set/reset pulses for a bank of WIDTH SR flip-flops. It never drives s and r together on any bit.
- Optionally reads the flops' q outputs back and retries until they match.
- Sits between control logic and SR flop banks as the initiating end of the s/r interface.

---
 rtl/sr_pkg.sv | 15 +
 rtl/sr_bank_driver.sv | 158 +++++++++++++++
 tb/tb_sr_bank_driver.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_pkg.sv
// Shared types and default sizing for the SR flop bank driver.
package sr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } sr_drv_state_t;

    localparam int SR_DRV_WIDTH     = 8;
    localparam int SR_DRV_PULSE_CYC = 2;
    localparam int SR_DRV_MAX_RETRY = 3;

endpackage

// File: rtl/sr_bank_driver.sv
// Sequencer that turns "write this value" requests into set/reset pulses
// for a bank of SR flops. Set and reset are derived from disjoint halves of
// the masked target, so no bit ever sees both asserted.
// Optional read-back verification with retries is enabled by defining
// SR_DRV_VERIFY_EN; without it the sequence ends after the settle cycle.
module sr_bank_driver
    import sr_pkg::*;
#(
    parameter int WIDTH     = SR_DRV_WIDTH,
    parameter int PULSE_CYC = SR_DRV_PULSE_CYC,
    parameter int MAX_RETRY = SR_DRV_MAX_RETRY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_target,
    input  logic [WIDTH-1:0] req_mask,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int PULSE_W = (PULSE_CYC > 0) ? $clog2(PULSE_CYC + 1) : 1;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(PULSE_CYC);
    localparam logic [PULSE_W-1:0] PULSE_ONE  = PULSE_W'(1);

    sr_drv_state_t    state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [PULSE_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             done_q, done_d;

`ifdef SR_DRV_VERIFY_EN
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
    logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   mismatch;

    assign mismatch = (q_fb ^ target_q) & mask_q;
    assign err      = err_q;
`else
    logic [WIDTH-1:0]   unused_q_fb;
    logic [RETRY_W-1:0] unused_retry_limit;

    assign unused_q_fb        = q_fb;
    assign unused_retry_limit = RETRY_W'(MAX_RETRY);
    assign err                = 1'b0;
`endif

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign s         = s_q;
    assign r         = r_q;
    assign done      = done_q;

    // Next-state sequencing, request capture and the registered s/r/done/err values.
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        mask_d      = mask_q;
        pulse_cnt_d = pulse_cnt_q;
        done_d      = 1'b0;
`ifdef SR_DRV_VERIFY_EN
        retry_cnt_d = retry_cnt_q;
        err_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    target_d    = req_target;
                    mask_d      = req_mask;
                    pulse_cnt_d = PULSE_ONE;
`ifdef SR_DRV_VERIFY_EN
                    retry_cnt_d = '0;
`endif
                    state_d     = DRIVE;
                end
            end
            DRIVE: begin
                if (pulse_cnt_q == PULSE_LAST) begin
                    state_d = SETTLE;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + PULSE_ONE;
                end
            end
            SETTLE: begin
`ifdef SR_DRV_VERIFY_EN
                state_d = CHECK;
`else
                state_d = IDLE;
                done_d  = 1'b1;
`endif
            end
            CHECK: begin
`ifdef SR_DRV_VERIFY_EN
                if (mismatch == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (retry_cnt_q < RETRY_LIMIT) begin
                    retry_cnt_d = retry_cnt_q + RETRY_W'(1);
                    pulse_cnt_d = PULSE_ONE;
                    state_d     = DRIVE;
                end else begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        s_d = '0;
        r_d = '0;
        if (state_d == DRIVE) begin
            s_d = mask_d & target_d;
            r_d = mask_d & ~target_d;
        end
    end

    // State and output registers; reset clears pulses immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            target_q    <= '0;
            mask_q      <= '0;
            pulse_cnt_q <= '0;
            s_q         <= '0;
            r_q         <= '0;
            done_q      <= 1'b0;
`ifdef SR_DRV_VERIFY_EN
            retry_cnt_q <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            mask_q      <= mask_d;
            pulse_cnt_q <= pulse_cnt_d;
            s_q         <= s_d;
            r_q         <= r_d;
            done_q      <= done_d;
`ifdef SR_DRV_VERIFY_EN
            retry_cnt_q <= retry_cnt_d;
            err_q       <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_sr_bank_driver.sv
// Self-checking bench for sr_bank_driver: an SR flop bank load, a
// timeline model of the request sequence compared every cycle, and
// directed requests with hand-computed expectations.
// Expectations follow SR_DRV_VERIFY_EN the same way the design does.
module tb_sr_bank_driver;

    localparam int WIDTH     = 8;
    localparam int PULSE_CYC = 2;
    localparam int MAX_RETRY = 3;
`ifdef SR_DRV_VERIFY_EN
    localparam int LAST_POS  = PULSE_CYC + 2;
    localparam int DONE_CYC  = 5;
    localparam int T4_DONE   = 0;
    localparam int T4_ERR    = 17;
    localparam int T4_DRIVE  = 8;
`else
    localparam int LAST_POS  = PULSE_CYC + 1;
    localparam int DONE_CYC  = 4;
    localparam int T4_DONE   = 4;
    localparam int T4_ERR    = 0;
    localparam int T4_DRIVE  = 2;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_target;
    logic [WIDTH-1:0] req_mask;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             done;
    logic             err;

    logic [WIDTH-1:0] flop_q;
    logic             flop_clr;
    logic [WIDTH-1:0] force0;
    logic             check_en;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sr_bank_driver #(
        .WIDTH    (WIDTH),
        .PULSE_CYC(PULSE_CYC),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_target(req_target),
        .req_mask  (req_mask),
        .q_fb      (q_fb),
        .s         (s),
        .r         (r),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // SR flop bank load; force0 pins selected q bits low to model stuck flops.
    always @(posedge clk) begin
        if (flop_clr) flop_q <= '0;
        else          flop_q <= (flop_q | s) & ~r;
    end
    assign q_fb = flop_q & ~force0;

    // Timeline model: position within the current attempt decides s/r,
    // the read-back at the end of each attempt decides done/retry/err.
    logic             m_busy;
    int               m_pos;
    int               m_tries;
    logic [WIDTH-1:0] m_tgt;
    logic [WIDTH-1:0] m_msk;
    logic             exp_done;
    logic             exp_err;
    logic [WIDTH-1:0] exp_s;
    logic [WIDTH-1:0] exp_r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy   <= 1'b0;
            m_pos    <= 0;
            m_tries  <= 0;
            m_tgt    <= '0;
            m_msk    <= '0;
            exp_done <= 1'b0;
            exp_err  <= 1'b0;
        end else begin
            exp_done <= 1'b0;
            exp_err  <= 1'b0;
            if (!m_busy) begin
                if (req_valid) begin
                    m_busy  <= 1'b1;
                    m_pos   <= 1;
                    m_tries <= 0;
                    m_tgt   <= req_target;
                    m_msk   <= req_mask;
                end
            end else if (m_pos < LAST_POS) begin
                m_pos <= m_pos + 1;
            end else begin
`ifdef SR_DRV_VERIFY_EN
                if (((q_fb ^ m_tgt) & m_msk) == '0) begin
                    m_busy   <= 1'b0;
                    exp_done <= 1'b1;
                end else if (m_tries < MAX_RETRY) begin
                    m_tries <= m_tries + 1;
                    m_pos   <= 1;
                end else begin
                    m_busy  <= 1'b0;
                    exp_err <= 1'b1;
                end
`else
                m_busy   <= 1'b0;
                exp_done <= 1'b1;
`endif
            end
        end
    end

    assign exp_s = (m_busy && m_pos <= PULSE_CYC) ? (m_msk & m_tgt)  : '0;
    assign exp_r = (m_busy && m_pos <= PULSE_CYC) ? (m_msk & ~m_tgt) : '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of the DUT against the model, away from the clock edge.
    always @(negedge clk) begin
        if (check_en && rst_n) begin
            checkOutput("cyc_s", 32'(s), 32'(exp_s));
            checkOutput("cyc_r", 32'(r), 32'(exp_r));
            checkOutput("cyc_s_and_r", 32'(s & r), 32'd0);
            checkOutput("cyc_busy", 32'(busy), 32'(m_busy));
            checkOutput("cyc_ready", 32'(req_ready), 32'(!m_busy));
            checkOutput("cyc_done", 32'(done), 32'(exp_done));
            checkOutput("cyc_err", 32'(err), 32'(exp_err));
        end
    end

    // Follow a running request from cycle start_cyc until done or err, with a cycle bound.
    task automatic runToEnd(input int start_cyc, output int dc, output int ec, output int drv);
        int cyc;
        cyc = start_cyc;
        dc  = 0;
        ec  = 0;
        drv = 0;
        while (dc == 0 && ec == 0 && cyc <= 60) begin
            if (s != '0 || r != '0) drv++;
            if (done) dc = cyc;
            if (err)  ec = cyc;
            if (dc == 0 && ec == 0) begin
                @(posedge clk); #2;
                cyc++;
            end
        end
        if (dc == 0 && ec == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL timeout: no done/err within 60 cycles at %0t", $time);
        end
    endtask

    // Present one request for a single cycle and follow it to completion.
    task automatic applyStimulus(input logic [WIDTH-1:0] tgt, input logic [WIDTH-1:0] msk,
                                 output int dc, output int ec, output int drv,
                                 output logic [WIDTH-1:0] s1, output logic [WIDTH-1:0] r1);
        req_target = tgt;
        req_mask   = msk;
        req_valid  = 1'b1;
        @(posedge clk); #2;
        req_valid  = 1'b0;
        s1 = s;
        r1 = r;
        runToEnd(1, dc, ec, drv);
    endtask

    initial begin
        int dc, ec, drv;
        int late_pulses;
        logic [WIDTH-1:0] s1, r1;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_target = '0;
        req_mask   = '0;
        force0     = '0;
        flop_clr   = 1'b1;
        check_en   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_s", 32'(s), 32'd0);
        checkOutput("rst_r", 32'(r), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_ready", 32'(req_ready), 32'd1);
        rst_n    = 1'b1;
        flop_clr = 1'b0;
        check_en = 1'b1;
        @(posedge clk); #2;

        // Full write A5 into cleared flops
        applyStimulus(8'hA5, 8'hFF, dc, ec, drv, s1, r1);
        checkOutput("t2_s", 32'(s1), 32'h00A5);
        checkOutput("t2_r", 32'(r1), 32'h005A);
        checkOutput("t2_done_cyc", 32'(dc), 32'(DONE_CYC));
        checkOutput("t2_err_cyc", 32'(ec), 32'd0);
        checkOutput("t2_q", 32'(flop_q), 32'h00A5);

        // Partial mask: only the low nibble is written
        flop_clr = 1'b1;
        @(posedge clk); #2;
        flop_clr = 1'b0;
        applyStimulus(8'hFF, 8'h0F, dc, ec, drv, s1, r1);
        checkOutput("t3_s", 32'(s1), 32'h000F);
        checkOutput("t3_r", 32'(r1), 32'h0000);
        checkOutput("t3_done_cyc", 32'(dc), 32'(DONE_CYC));
        checkOutput("t3_q", 32'(flop_q), 32'h000F);

        // Stuck flop: retries exhaust with verification, plain done without
        force0 = 8'h01;
        applyStimulus(8'h01, 8'h01, dc, ec, drv, s1, r1);
        checkOutput("t4_done_cyc", 32'(dc), 32'(T4_DONE));
        checkOutput("t4_err_cyc", 32'(ec), 32'(T4_ERR));
        checkOutput("t4_drive_cycles", 32'(drv), 32'(T4_DRIVE));
        force0 = '0;
        @(posedge clk); #2;

        // Empty mask still runs the sequence and completes
        applyStimulus(8'h5A, 8'h00, dc, ec, drv, s1, r1);
        checkOutput("mask0_drive_cycles", 32'(drv), 32'd0);
        checkOutput("mask0_done_cyc", 32'(dc), 32'(DONE_CYC));

        // Asynchronous reset in the middle of DRIVE
        req_target = 8'hF0;
        req_mask   = 8'hFF;
        req_valid  = 1'b1;
        @(posedge clk); #2;
        req_valid  = 1'b0;
        checkOutput("t5_s_pre", 32'(s), 32'h00F0);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_s", 32'(s), 32'd0);
        checkOutput("t5_r", 32'(r), 32'd0);
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_ready", 32'(req_ready), 32'd1);
        checkOutput("t5_done", 32'(done), 32'd0);
        checkOutput("t5_err", 32'(err), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        late_pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || err || busy) late_pulses++;
            @(posedge clk); #2;
        end
        checkOutput("t5_quiet_after", 32'(late_pulses), 32'd0);
        checkOutput("t5_ready_after", 32'(req_ready), 32'd1);

        // Back-to-back: second request accepted in the done cycle of the first
        req_target = 8'hA5;
        req_mask   = 8'hFF;
        req_valid  = 1'b1;
        @(posedge clk); #2;
        req_target = 8'h3C;
        checkOutput("t6_s_first", 32'(s), 32'h00A5);
        runToEnd(1, dc, ec, drv);
        checkOutput("t6_done_cyc", 32'(dc), 32'(DONE_CYC));
        checkOutput("t6_ready_in_done", 32'(req_ready), 32'd1);
        @(posedge clk); #2;
        req_valid = 1'b0;
        checkOutput("t6_s_second", 32'(s), 32'h003C);
        checkOutput("t6_r_second", 32'(r), 32'h00C3);
        runToEnd(1, dc, ec, drv);
        checkOutput("t6_done2_cyc", 32'(dc), 32'(DONE_CYC));
        checkOutput("t6_q", 32'(flop_q), 32'h003C);
        @(posedge clk); #2;

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop if the directed sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
